// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline stage with a two-entry skid buffer.
// A generic payload moves with a valid/ready handshake at full throughput
// under backpressure; flush_i drops every held entry.
// Optional build macro: PIPE_STALL_CNT_EN adds the stall_cnt output and its
// saturating counter (cycles spent with out_valid & !out_ready).
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | nothing held, in_ready=1, out_valid=0
// ONE   | main entry valid, skid empty, in_ready=1
// TWO   | main and skid entries valid, in_ready=0
module pipe_skid_reg #(
    parameter int PAYLOAD_W = 71,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Both widths must be at least one bit; catch bad overrides at elaboration.
    generate
        if (PAYLOAD_W < 1) begin : g_bad_payload_w
            $error("pipe_skid_reg: PAYLOAD_W must be >= 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("pipe_skid_reg: CNT_W must be >= 1");
        end
    endgenerate

    state_t                 state_q;
    state_t                 state_d;
    logic [PAYLOAD_W-1:0]   main_data;
    logic [PAYLOAD_W-1:0]   skid_data;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   load_main;
    logic                   main_from_skid;
    logic                   load_skid;

    // Handshake flags come straight from the state register, so in_ready
    // and out_valid are registered outputs with no combinational path.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_data;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and data-register load enables.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush wins over everything. The incoming beat is discarded and the
        // data registers keep their old contents; the valid bits are the only
        // truth, so stale data is never presented.
        if (flush_i) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Main entry: loads from the input or is refilled from the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
        end else if (load_main) begin
            main_data <= main_from_skid ? skid_data : in_data;
        end
    end

    // Skid entry: catches the beat accepted while the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of backpressured cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed vectors plus a random handshake run,
// checked by a queue scoreboard and a separate output monitor.
module tb_pipe_skid_reg;

    localparam int W = 71;
    localparam int C = 4;

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [C-1:0] stall_cnt;
`endif

    int n_cmp;
    int n_err;
    logic [W-1:0] exp_q[$];
    logic         stall_seen;
    logic [W-1:0] prev_data;

    pipe_skid_reg #(
        .PAYLOAD_W (W),
        .CNT_W     (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; called just after a rising edge. Accepted beats
    // are pushed to the scoreboard at the sampling point.
    task automatic step(input logic v, input logic [W-1:0] d, input logic fl, input logic ordy);
        in_valid  = v;
        in_data   = d;
        flush_i   = fl;
        out_ready = ordy;
        @(negedge clk);
        if (rst_n && v && in_ready && !fl) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output transfer, checks stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("hold_valid", W'(out_valid), W'(1));
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got %h expected no output", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            if (flush_i) exp_q.delete();
            stall_seen = out_valid && !out_ready && !flush_i;
            prev_data  = out_data;
        end
    end

    initial begin
        logic [95:0] r;
        n_cmp      = 0;
        n_err      = 0;
        stall_seen = 1'b0;
        prev_data  = '0;
        rst_n      = 1'b1;
        flush_i    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_occupancy", W'(occupancy), W'(0));
`ifdef PIPE_STALL_CNT_EN
        chk("rst_stall_cnt", W'(stall_cnt), W'(0));
`endif
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single beat latency, then a 100-beat stream
        step(1'b1, W'('hA5), 1'b0, 1'b1);
        chk("t1_out_valid", W'(out_valid), W'(1));
        chk("t1_out_data", out_data, W'('hA5));
        chk("t1_occupancy", W'(occupancy), W'(1));
        for (int i = 0; i < 100; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b1);
            chk("t1_stream_valid", W'(out_valid), W'(1));
            chk("t1_stream_data", out_data, W'(i));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t1_drained", W'(occupancy), W'(0));

        // 2: backpressure fills skid, third push refused, drain in order
        step(1'b1, W'('h11), 1'b0, 1'b0);
        chk("t2_occ1", W'(occupancy), W'(1));
        step(1'b1, W'('h22), 1'b0, 1'b0);
        chk("t2_occ2", W'(occupancy), W'(2));
        chk("t2_in_ready", W'(in_ready), W'(0));
        chk("t2_out_data", out_data, W'('h11));
        step(1'b1, W'('h33), 1'b0, 1'b0);
        chk("t2_occ_full", W'(occupancy), W'(2));
        chk("t2_out_hold", out_data, W'('h11));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_second", out_data, W'('h22));
        chk("t2_occ_after", W'(occupancy), W'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_empty", W'(occupancy), W'(0));

        // 3: flush from TWO with a pending input, then flush from ONE with
        //    a simultaneous output transfer
        step(1'b1, W'('h55), 1'b0, 1'b0);
        step(1'b1, W'('h66), 1'b0, 1'b0);
        step(1'b1, W'('h44), 1'b1, 1'b0);
        chk("t3_out_valid", W'(out_valid), W'(0));
        chk("t3_occupancy", W'(occupancy), W'(0));
        chk("t3_in_ready", W'(in_ready), W'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_no_0x44", W'(out_valid), W'(0));
        step(1'b1, W'('h77), 1'b0, 1'b0);
        step(1'b1, W'('h88), 1'b1, 1'b1);
        chk("t3_one_flush_occ", W'(occupancy), W'(0));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_no_0x88", W'(out_valid), W'(0));

        // 4: reset while holding two entries
        step(1'b1, W'('h99), 1'b0, 1'b0);
        step(1'b1, W'('hAA), 1'b0, 1'b0);
        chk("t4_pre_occ", W'(occupancy), W'(2));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t4_out_valid", W'(out_valid), W'(0));
        chk("t4_out_data", out_data, W'(0));
        chk("t4_occupancy", W'(occupancy), W'(0));
        chk("t4_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t4_no_stale", W'(out_valid), W'(0));
`ifdef PIPE_STALL_CNT_EN
        chk("t4_stall_cnt_clr", W'(stall_cnt), W'(0));

        // 6: stall counter saturation survives flush
        step(1'b1, W'('h12), 1'b0, 1'b0);
        chk("t6_start", W'(stall_cnt), W'(0));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("t6_five", W'(stall_cnt), W'(5));
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("t6_saturated", W'(stall_cnt), W'(15));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_after_flush", W'(stall_cnt), W'(15));
        chk("t6_flush_occ", W'(occupancy), W'(0));
`endif

        // 5: random handshakes with occasional flush
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 3) != 0, r[W-1:0],
                 $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (4) step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_drained", W'(occupancy), W'(0));
        chk("t5_queue_empty", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
